// File: rtl/ppu_spr_render.sv
// Per-dot sprite renderer: eight X down-counters/pattern shifters plus
// sprite-vs-sprite and sprite-vs-background priority and sprite-0 hit.
module ppu_spr_render (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_idx,
    input  logic [9:0] scanline,
    input  logic       ld,
    input  logic [2:0] ld_slot,
    input  logic [7:0] ld_bmp_low,
    input  logic [7:0] ld_bmp_high,
    input  logic [7:0] ld_attr,
    input  logic [7:0] ld_x,
    input  logic [3:0] bg_pixel,
    input  logic       show_bg,
    input  logic       show_spr,
    input  logic       show_bg_left,
    input  logic       show_spr_left,
    output logic [4:0] pixel_out,
    output logic       spr0_hit
);

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned PIX_W     = 5;

    logic [BYTE_W-1:0] bmp_low_q  [NUM_SLOTS];
    logic [BYTE_W-1:0] bmp_low_d  [NUM_SLOTS];
    logic [BYTE_W-1:0] bmp_high_q [NUM_SLOTS];
    logic [BYTE_W-1:0] bmp_high_d [NUM_SLOTS];
    logic [BYTE_W-1:0] attr_q     [NUM_SLOTS];
    logic [BYTE_W-1:0] attr_d     [NUM_SLOTS];
    logic [BYTE_W-1:0] xcnt_q     [NUM_SLOTS];
    logic [BYTE_W-1:0] xcnt_d     [NUM_SLOTS];
    logic [PIX_W-1:0]  pixel_out_q, pixel_out_d;
    logic              spr0_hit_q, spr0_hit_d;

    logic [1:0]        pat [NUM_SLOTS];
    logic              visible;
    logic              left_dot;
    logic              spr_found;
    logic [1:0]        win_pat;
    logic [BYTE_W-1:0] win_attr;
    logic              spr0_opaque;
    logic              spr_ok;
    logic              spr_opaque;
    logic              bg_opaque;
    logic              hit_set;
    logic              unused_attr_bits;

    // Slot state, output pixel and sticky hit registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                bmp_low_q[i]  <= '0;
                bmp_high_q[i] <= '0;
                attr_q[i]     <= '0;
                xcnt_q[i]     <= 8'hFF;
            end
            pixel_out_q <= '0;
            spr0_hit_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                bmp_low_q[i]  <= bmp_low_d[i];
                bmp_high_q[i] <= bmp_high_d[i];
                attr_q[i]     <= attr_d[i];
                xcnt_q[i]     <= xcnt_d[i];
            end
            pixel_out_q <= pixel_out_d;
            spr0_hit_q  <= spr0_hit_d;
        end
    end

    // Dot classification and per-slot current pattern
    always_comb begin
        visible  = (scanline >= 10'd1) && (scanline <= 10'd240) && (x_idx < 10'd256);
        left_dot = (x_idx < 10'd8);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pat[i] = (xcnt_q[i] == 8'd0) ? {bmp_high_q[i][7], bmp_low_q[i][7]} : 2'b00;
        end
    end

    // Counter/shifter advance on visible dots; slot loads during fetch dots
    always_comb begin
        bmp_low_d  = bmp_low_q;
        bmp_high_d = bmp_high_q;
        attr_d     = attr_q;
        xcnt_d     = xcnt_q;
        if (visible) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (xcnt_q[i] != 8'd0) begin
                    xcnt_d[i] = xcnt_q[i] - 8'd1;
                end else begin
                    bmp_low_d[i]  = {bmp_low_q[i][6:0], 1'b0};
                    bmp_high_d[i] = {bmp_high_q[i][6:0], 1'b0};
                end
            end
        end
        if (ld && (x_idx >= 10'd256)) begin
            bmp_low_d[ld_slot]  = ld_bmp_low;
            bmp_high_d[ld_slot] = ld_bmp_high;
            attr_d[ld_slot]     = ld_attr;
            xcnt_d[ld_slot]     = ld_x;
        end
    end

    // Lowest-indexed opaque slot wins; sprite-0 hit looks at every opaque slot
    always_comb begin
        spr_found   = 1'b0;
        win_pat     = 2'b00;
        win_attr    = '0;
        spr0_opaque = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!spr_found && (pat[i] != 2'b00)) begin
                spr_found = 1'b1;
                win_pat   = pat[i];
                win_attr  = attr_q[i];
            end
            if (attr_q[i][2] && (pat[i] != 2'b00)) begin
                spr0_opaque = 1'b1;
            end
        end
    end

    // Clipping, priority mux and sprite-0 hit
    always_comb begin
        spr_ok      = show_spr && !(left_dot && !show_spr_left);
        spr_opaque  = spr_found && spr_ok;
        bg_opaque   = show_bg && !(left_dot && !show_bg_left) && (bg_pixel[1:0] != 2'b00);
        pixel_out_d = '0;
        if (visible) begin
            if (spr_opaque && !(bg_opaque && win_attr[5])) begin
                pixel_out_d = {1'b1, win_attr[1:0], win_pat};
            end else if (bg_opaque) begin
                pixel_out_d = {1'b0, bg_pixel};
            end
        end
        hit_set    = visible && spr0_opaque && spr_ok && bg_opaque && (x_idx != 10'd255);
        spr0_hit_d = spr0_hit_q;
        if ((scanline == 10'd0) && (x_idx == 10'd0)) begin
            spr0_hit_d = 1'b0;
        end else if (hit_set) begin
            spr0_hit_d = 1'b1;
        end
    end

    // Attribute bits that this stage stores but never interprets
    always_comb begin
        unused_attr_bits = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            unused_attr_bits = unused_attr_bits ^ (^{attr_q[i][7:6], attr_q[i][4:3]});
        end
    end

    assign pixel_out = pixel_out_q;
    assign spr0_hit  = spr0_hit_q;

endmodule

// File: tb/tb_ppu_spr_render.sv
// Scoreboard bench for ppu_spr_render: a dot-level reference model queues the
// expected {pixel_out, spr0_hit} for each cycle and each scenario drains it.
module tb_ppu_spr_render;

    typedef struct {
        int         sl;
        int         dot;
        logic [5:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x_idx, scanline;
    logic       ld;
    logic [2:0] ld_slot;
    logic [7:0] ld_bmp_low, ld_bmp_high, ld_attr, ld_x;
    logic [3:0] bg_pixel;
    logic       show_bg, show_spr, show_bg_left, show_spr_left;
    logic [4:0] pixel_out;
    logic       spr0_hit;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] t_low [8], t_high [8], t_attr [8], t_x [8];
    logic [7:0] m_low [8], m_high [8], m_attr [8];
    int         m_x   [8];
    logic       m_hit;
    logic [3:0] bg_line [256];

    exp_t       exp_q[$];
    logic [5:0] obs_q[$];

    ppu_spr_render dut (
        .clk(clk), .reset(reset), .x_idx(x_idx), .scanline(scanline),
        .ld(ld), .ld_slot(ld_slot), .ld_bmp_low(ld_bmp_low), .ld_bmp_high(ld_bmp_high),
        .ld_attr(ld_attr), .ld_x(ld_x), .bg_pixel(bg_pixel),
        .show_bg(show_bg), .show_spr(show_spr), .show_bg_left(show_bg_left),
        .show_spr_left(show_spr_left), .pixel_out(pixel_out), .spr0_hit(spr0_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] m_pat(input int s, input int d);
        int off;
        off = d - m_x[s];
        if (off >= 0 && off < 8) return {m_high[s][7-off], m_low[s][7-off]};
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            m_low[s] = 8'h00; m_high[s] = 8'h00; m_attr[s] = 8'h00; m_x[s] = 255;
        end
        m_hit = 1'b0;
    endtask

    task automatic clear_slots();
        for (int s = 0; s < 8; s++) begin
            t_low[s] = 8'h00; t_high[s] = 8'h00; t_attr[s] = 8'h00; t_x[s] = 8'h00;
        end
        for (int d = 0; d < 256; d++) bg_line[d] = 4'h0;
    endtask

    // Drive one dot, queue the model's prediction, capture the DUT result
    task automatic step(input int sl, input int d, input bit do_ld, input int slot);
        exp_t e;
        logic [1:0] p, wp;
        logic [4:0] pix;
        int win;
        bit s0, spr_ok, bg_op;
        scanline    = 10'(sl);
        x_idx       = 10'(d);
        ld          = do_ld;
        ld_slot     = 3'(slot);
        ld_bmp_low  = t_low[slot];
        ld_bmp_high = t_high[slot];
        ld_attr     = t_attr[slot];
        ld_x        = t_x[slot];
        bg_pixel    = (d < 256) ? bg_line[d] : 4'h0;
        pix = 5'h00;
        wp  = 2'b00;
        if (sl == 0 && d == 0) m_hit = 1'b0;
        if (sl >= 1 && sl <= 240 && d < 256) begin
            win = -1;
            s0  = 1'b0;
            for (int s = 0; s < 8; s++) begin
                p = m_pat(s, d);
                if (p != 2'b00 && win < 0) begin win = s; wp = p; end
                if (p != 2'b00 && m_attr[s][2]) s0 = 1'b1;
            end
            spr_ok = show_spr && (d >= 8 || show_spr_left);
            bg_op  = show_bg && (d >= 8 || show_bg_left) && (bg_pixel[1:0] != 2'b00);
            if (win >= 0 && spr_ok && !(bg_op && m_attr[win][5]))
                pix = {1'b1, m_attr[win][1:0], wp};
            else if (bg_op)
                pix = {1'b0, bg_pixel};
            if (s0 && spr_ok && bg_op && d != 255) m_hit = 1'b1;
        end
        e.sl = sl; e.dot = d; e.val = {pix, m_hit};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q.push_back({pixel_out, spr0_hit});
        if (do_ld && d >= 256) begin
            m_low[slot] = t_low[slot]; m_high[slot] = t_high[slot];
            m_attr[slot] = t_attr[slot]; m_x[slot] = int'(t_x[slot]);
        end
        ld = 1'b0;
    endtask

    task automatic run_line(input int sl, input int first, input int last, input bit do_load);
        if (do_load) for (int s = 0; s < 8; s++) step(sl, 256 + s, 1'b1, s);
        for (int d = first; d <= last; d++) step(sl, d, 1'b0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pixel_out !== 5'h00) begin
            n_fail++; $display("FAIL reset_pixel got=%h exp=00", pixel_out);
        end
        n_checks++;
        if (spr0_hit !== 1'b0) begin
            n_fail++; $display("FAIL reset_hit got=%b exp=0", spr0_hit);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_single_sprite();
        exp_t e; logic [5:0] o;
        clear_slots();
        t_low[0] = 8'h80; t_x[0] = 8'd10;
        run_line(5, 0, 255, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL single_sprite sl=%0d dot=%0d got pix=%h hit=%b exp pix=%h hit=%b",
                         e.sl, e.dot, o[5:1], o[0], e.val[5:1], e.val[0]);
            end
        end
    endtask

    task automatic test_slot_priority();
        exp_t e; logic [5:0] o;
        clear_slots();
        t_low[0] = 8'hFF; t_x[0] = 8'd20; t_attr[0] = 8'h01;
        t_low[3] = 8'hFF; t_x[3] = 8'd20; t_attr[3] = 8'h02;
        run_line(6, 0, 63, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL slot_priority sl=%0d dot=%0d got pix=%h hit=%b exp pix=%h hit=%b",
                         e.sl, e.dot, o[5:1], o[0], e.val[5:1], e.val[0]);
            end
        end
    endtask

    task automatic test_bg_priority();
        exp_t e; logic [5:0] o;
        clear_slots();
        t_low[0] = 8'hFF; t_x[0] = 8'd30; t_attr[0] = 8'h20;
        for (int d = 30; d < 38; d++) bg_line[d] = 4'h6;
        run_line(7, 0, 63, 1'b1);
        for (int d = 30; d < 38; d++) bg_line[d] = 4'h4;
        run_line(8, 0, 63, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL bg_priority sl=%0d dot=%0d got pix=%h hit=%b exp pix=%h hit=%b",
                         e.sl, e.dot, o[5:1], o[0], e.val[5:1], e.val[0]);
            end
        end
    endtask

    task automatic test_spr0_hit();
        exp_t e; logic [5:0] o;
        clear_slots();
        for (int d = 0; d < 256; d++) bg_line[d] = 4'h1;
        t_low[0] = 8'hFF; t_x[0] = 8'd255; t_attr[0] = 8'h04;
        run_line(9, 0, 255, 1'b1);
        t_x[0] = 8'd100;
        run_line(10, 0, 255, 1'b1);
        run_line(11, 0, 50, 1'b1);
        run_line(0, 0, 3, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL spr0_hit sl=%0d dot=%0d got pix=%h hit=%b exp pix=%h hit=%b",
                         e.sl, e.dot, o[5:1], o[0], e.val[5:1], e.val[0]);
            end
        end
    endtask

    task automatic test_left_clip();
        exp_t e; logic [5:0] o;
        clear_slots();
        for (int d = 0; d < 256; d++) bg_line[d] = 4'h1;
        t_low[0] = 8'hFF; t_x[0] = 8'd0; t_attr[0] = 8'h04;
        show_spr_left = 1'b0;
        run_line(12, 0, 15, 1'b1);
        show_spr_left = 1'b1;
        run_line(13, 0, 15, 1'b1);
        run_line(0, 0, 1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL left_clip sl=%0d dot=%0d got pix=%h hit=%b exp pix=%h hit=%b",
                         e.sl, e.dot, o[5:1], o[0], e.val[5:1], e.val[0]);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        exp_t e; logic [5:0] o;
        for (int k = 0; k < 5; k++) begin
            for (int s = 0; s < 8; s++) begin
                t_low[s]  = 8'($urandom);
                t_high[s] = 8'($urandom);
                t_attr[s] = 8'($urandom);
                t_x[s]    = 8'($urandom_range(0, 255));
            end
            for (int d = 0; d < 256; d++) bg_line[d] = 4'($urandom);
            show_bg       = ($urandom_range(0, 3) != 0);
            show_spr      = ($urandom_range(0, 3) != 0);
            show_bg_left  = ($urandom_range(0, 1) != 0);
            show_spr_left = ($urandom_range(0, 1) != 0);
            run_line(20 + k, 0, 255, 1'b1);
            if (k == 2) run_line(0, 0, 2, 1'b0);
        end
        show_bg = 1'b1; show_spr = 1'b1; show_bg_left = 1'b1; show_spr_left = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL random_lines sl=%0d dot=%0d got pix=%h hit=%b exp pix=%h hit=%b",
                         e.sl, e.dot, o[5:1], o[0], e.val[5:1], e.val[0]);
            end
        end
    endtask

    task automatic test_reset_mid_line();
        exp_t e; logic [5:0] o;
        run_line(0, 0, 0, 1'b0);
        clear_slots();
        for (int d = 0; d < 256; d++) bg_line[d] = 4'h1;
        t_low[0] = 8'hFF; t_x[0] = 8'd48; t_attr[0] = 8'h04;
        run_line(3, 0, 50, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL pre_reset sl=%0d dot=%0d got pix=%h hit=%b exp pix=%h hit=%b",
                         e.sl, e.dot, o[5:1], o[0], e.val[5:1], e.val[0]);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (pixel_out !== 5'h00) begin
            n_fail++; $display("FAIL mid_reset_pixel got=%h exp=00", pixel_out);
        end
        n_checks++;
        if (spr0_hit !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_hit got=%b exp=0", spr0_hit);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_ignored_load();
        exp_t e; logic [5:0] o;
        t_low[0] = 8'hFF; t_high[0] = 8'hFF; t_x[0] = 8'd0; t_attr[0] = 8'h04;
        step(3, 40, 1'b1, 0);
        run_line(3, 41, 255, 1'b0);
        run_line(4, 0, 255, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL ignored_load sl=%0d dot=%0d got pix=%h hit=%b exp pix=%h hit=%b",
                         e.sl, e.dot, o[5:1], o[0], e.val[5:1], e.val[0]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        x_idx = 10'd0; scanline = 10'd261;
        ld = 1'b0; ld_slot = 3'd0;
        ld_bmp_low = 8'h00; ld_bmp_high = 8'h00; ld_attr = 8'h00; ld_x = 8'h00;
        bg_pixel = 4'h0;
        show_bg = 1'b1; show_spr = 1'b1; show_bg_left = 1'b1; show_spr_left = 1'b1;
        clear_slots();
        model_clear();
        test_reset();
        test_single_sprite();
        test_slot_priority();
        test_bg_priority();
        test_spr0_hit();
        test_left_clip();
        test_back_to_back_random();
        test_reset_mid_line();
        test_ignored_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_spr_render.md
# ppu_spr_render

Per-dot sprite rendering and pixel-priority stage of the PPU, directly downstream of sprite evaluation/fetch. During dots 256–319 it accepts up to 8 pre-fetched sprite slivers (pattern bytes already horizontally flipped, attribute byte, X position) for the next scanline. During visible dots 0–255 it runs eight X down-counters and pattern shifters and resolves sprite-vs-sprite and sprite-vs-background priority. It emits a registered 5-bit palette address and the sticky sprite-0 hit flag.

## Interface
Parameters:
- none

Ports (clock and reset first):
- clk  in  1  PPU dot clock
- reset  in  1  asynchronous, active-high
- x_idx  in  10  current dot within scanline (0–340)
- scanline  in  10  current scanline; 0 = prerender, 1–240 = visible
- ld  in  1  slot load strobe, one cycle
- ld_slot  in  3  slot index to load (0 = highest priority)
- ld_bmp_low  in  8  pattern plane 0, bit 7 = leftmost pixel
- ld_bmp_high  in  8  pattern plane 1, bit 7 = leftmost pixel
- ld_attr  in  8  [1:0] palette, [2] sprite-0 flag, [5] behind-background
- ld_x  in  8  sprite X position
- bg_pixel  in  4  background {palette[1:0], pattern[1:0]} for dot x_idx, same cycle
- show_bg, show_spr  in  1  rendering enables
- show_bg_left, show_spr_left  in  1  enable for dots 0–7
- pixel_out  out  5  palette RAM address; bit 4 = sprite palette
- spr0_hit  out  1  sticky sprite-0 hit

## Operation
- Per slot: bmp_low[7:0], bmp_high[7:0], attr[7:0], xcnt[7:0].
- Load: when ld=1 and x_idx ≥ 256, slot ld_slot takes all four ld_* values. ld with x_idx < 256 is ignored.
- Visible dot: scanline 1–240 and x_idx 0–255. For each slot, every visible dot:
  - if xcnt ≠ 0: decrement xcnt; pattern = 0.
  - if xcnt = 0: pattern = {bmp_high[7], bmp_low[7]}; shift both bytes left 1, fill 0.
- Outside visible dots, counters and shifters hold.
- A slot loaded with X is therefore opaque-capable at dots X..X+7. Pixels past dot 255 are dropped.
- Sprite select: the lowest-indexed slot with pattern ≠ 0 wins. Its attr supplies palette, priority and sprite-0 flag.
- Clipping:
  - sprite is transparent if show_spr=0, or x_idx<8 and show_spr_left=0.
  - background is transparent if show_bg=0, or x_idx<8 and show_bg_left=0, or bg_pixel[1:0]=0.
- Mux:
  - both transparent → 5'h00.
  - only bg opaque → {0, bg_pixel}.
  - only sprite opaque → {1, attr[1:0], pattern}.
  - both opaque → sprite if attr[5]=0, else bg.
- Sprite-0 hit: set when, on a visible dot, the winning or any opaque slot with attr[2]=1 is opaque after clipping, bg is opaque after clipping, and x_idx ≠ 255. Priority bit is ignored for the hit.
- spr0_hit clears at scanline 0, x_idx 0. The clear condition never coincides with a set, since scanline 0 is not visible.
- Non-visible dots: pixel_out = 5'h00.

## Timing
- Reset values:
  - pixel_out = 0, spr0_hit = 0.
  - all bmp and attr registers = 0; all xcnt = 8'hFF.
  - Result: nothing renders until a load occurs.
- Latency:
  - pixel_out in cycle t+1 reflects dot x_idx sampled in cycle t.
  - spr0_hit rises in cycle t+1 after the hitting dot.
- A load takes effect the next cycle. Multiple loads to one slot: the last wins.
- Reset mid-line returns everything to reset values immediately (asynchronous). Rendering resumes only after new loads.
- Unloaded slots keep stale state. Evaluation loads all 8 slots every line, using zero bitmaps for empty slots.

## Test plan
- Slot 0 loaded ld_x=10, bmp_low=8'h80, bmp_high=0, attr=0, bg=0, scanline 5 → pixel_out=5'h11 for dot 10 only (cycle after x_idx=10); 5'h00 at all other dots.
- Slots 0 and 3 both at ld_x=20, bmp_low=8'hFF, attr palettes 1 and 2 → dots 20–27 output 5'h15 (slot 0 wins); slot 3 never visible.
- Sprite attr[5]=1, bg_pixel=4'h6 across dots 30–37 → pixel_out=5'h06. With bg_pixel=4'h4 (transparent) → sprite color.
- Sprite-0 (attr=8'h04) at ld_x=255 with opaque bg → no hit. Same sprite at ld_x=100 → spr0_hit=1 the cycle after dot 100, held until scanline 0 dot 0.
- Sprite at ld_x=0, show_spr_left=0 → dots 0–7 output bg/backdrop, no hit. Repeat with show_spr_left=1 → sprite visible at dot 0.
- Assert reset at dot 50 mid-sprite → pixel_out=0 and spr0_hit=0 immediately. ld at x_idx=40 ignored.
